// File: rtl/snn_run_sequencer.sv
// snn_run_sequencer: debounces the run switch and sequences start/run/done/fault for the SNN core
module snn_run_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch_working,
  input  logic       core_done,
  output logic       core_start,
  output logic       core_enable,
  output logic       debounced_sw,
  output logic       led_run,
  output logic       led_done,
  output logic       led_fault,
  output logic [7:0] run_count
);
  typedef enum logic [2:0] {IDLE, START, RUN, DONE, FAULT} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic s1, s2;
  logic [CNT_W-1:0] db_cnt, wd;
  // two-flop synchroniser feeding a stability counter that flips the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, debounced_sw} <= '0;
      db_cnt <= '0;
    end else begin
      s1 <= switch_working;
      s2 <= s1;
      if (s2 == debounced_sw) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        debounced_sw <= ~debounced_sw;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  // state register, watchdog (cleared outside RUN) and saturating completed-run counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wd <= '0;
      run_count <= '0;
    end else begin
      state <= state_nxt;
      wd <= (state == RUN) ? wd + 1'b1 : '0;
      if (state == RUN && core_done && run_count != 8'hFF) run_count <= run_count + 8'd1;
    end
  end
  // next state: in RUN, done beats abort beats timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        state_nxt = debounced_sw ? START : IDLE;
      START:       state_nxt = RUN;
      RUN:         state_nxt = core_done ? DONE : !debounced_sw ? IDLE : (wd == WD_LAST) ? FAULT : RUN;
      DONE, FAULT: state_nxt = debounced_sw ? state : IDLE;
      default:     state_nxt = IDLE;
    endcase
  end
  // outputs decoded purely from the state register
  always_comb begin
    core_start = state == START;
    core_enable = state == START || state == RUN;
    led_run = core_enable;
    led_done = state == DONE;
    led_fault = state == FAULT;
  end
endmodule

// File: tb/tb_snn_run_sequencer.sv
// tb_snn_run_sequencer: directed checks of debounce, run sequencing, watchdog, reset and count saturation
module tb_snn_run_sequencer;
  logic clk = 0, rst = 1, switch_working = 0, core_done = 0;
  logic core_start, core_enable, debounced_sw, led_run, led_done, led_fault;
  logic [7:0] run_count;
  int tests = 0, fails = 0, starts = 0, n, ec;

  snn_run_sequencer #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .switch_working(switch_working), .core_done(core_done),
    .core_start(core_start), .core_enable(core_enable), .debounced_sw(debounced_sw),
    .led_run(led_run), .led_done(led_done), .led_fault(led_fault), .run_count(run_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (core_start) starts++;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_start(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (core_start) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, core_start, 0);
    check({tag, "_en"}, core_enable, 0);
    check({tag, "_db"}, debounced_sw, 0);
    check({tag, "_run"}, led_run, 0);
    check({tag, "_done"}, led_done, 0);
    check({tag, "_fault"}, led_fault, 0);
    check({tag, "_cnt"}, run_count, 0);
  endtask

  task automatic do_run();
    switch_working = 1;
    wait_start(n);
    tick();
    core_done = 1;
    tick();
    core_done = 0;
    switch_working = 0;
    repeat (7) tick();
  endtask

  initial begin
    // 1: reset, then a normal run
    repeat (5) tick();
    check_all_zero("rst");
    rst = 0;
    switch_working = 1;
    repeat (5) tick();
    check("db_edge4", debounced_sw, 0);
    tick();
    check("db_edge5", debounced_sw, 1);
    check("start_edge5", core_start, 0);
    tick();
    check("start_edge6", core_start, 1);
    check("en_start", core_enable, 1);
    check("ledrun_start", led_run, 1);
    tick();
    check("start_pulse", core_start, 0);
    check("en_run", core_enable, 1);
    repeat (8) tick();
    core_done = 1;
    tick();
    core_done = 0;
    check("t1_done", led_done, 1);
    check("t1_cnt", run_count, 1);
    check("t1_en", core_enable, 0);
    check("t1_run", led_run, 0);
    core_done = 1;
    tick();
    core_done = 0;
    check("done_in_done", run_count, 1);
    check("stay_done", led_done, 1);
    switch_working = 0;
    repeat (7) tick();
    check("done_to_idle", led_done, 0);
    // 2: short glitch is rejected
    ec = starts;
    switch_working = 1;
    repeat (3) tick();
    switch_working = 0;
    repeat (15) tick();
    check("glitch_db", debounced_sw, 0);
    check("glitch_starts", starts, ec);
    check("glitch_run", led_run, 0);
    // 3: watchdog timeout
    switch_working = 1;
    wait_start(n);
    check("t3_lat", n, 7);
    ec = 0;
    for (int i = 0; i < 100; i++) begin
      if (!core_enable) break;
      ec++;
      tick();
    end
    check("t3_en_cycles", ec, 21);
    check("t3_fault", led_fault, 1);
    check("t3_cnt", run_count, 1);
    switch_working = 0;
    repeat (7) tick();
    check("t3_clear", led_fault, 0);
    switch_working = 1;
    wait_start(n);
    check("t3_restart", n, 7);
    check("t3_cnt2", run_count, 1);
    // 4a: switch falls in RUN and core_done arrives with debounced_sw already low
    switch_working = 0;
    repeat (6) tick();
    check("t4_db_low", debounced_sw, 0);
    check("t4_in_run", led_run, 1);
    core_done = 1;
    tick();
    core_done = 0;
    check("t4_done", led_done, 1);
    check("t4_cnt", run_count, 2);
    tick();
    check("t4_idle", led_done, 0);
    // 4b: abort without done; core_done during START ignored
    switch_working = 1;
    wait_start(n);
    check("t4b_lat", n, 7);
    core_done = 1;
    switch_working = 0;
    tick();
    core_done = 0;
    check("start_done_ign", led_done, 0);
    check("start_to_run", led_run, 1);
    repeat (6) tick();
    check("abort_run", led_run, 0);
    check("abort_en", core_enable, 0);
    check("abort_done", led_done, 0);
    check("abort_cnt", run_count, 2);
    // 5: reset mid-run with switch held high
    switch_working = 1;
    wait_start(n);
    repeat (3) tick();
    check("t5_in_run", core_enable, 1);
    rst = 1;
    tick();
    check_all_zero("midrst");
    rst = 0;
    wait_start(n);
    check("t5_lat", n, 7);
    // 6: saturation of run_count
    tick();
    core_done = 1;
    tick();
    core_done = 0;
    check("t6_first", run_count, 1);
    switch_working = 0;
    repeat (7) tick();
    for (int i = 2; i <= 257; i++) begin
      do_run();
      if (i == 254) check("cnt_254", run_count, 254);
      if (i == 255) check("cnt_255", run_count, 255);
    end
    check("cnt_sat", run_count, 255);
    core_done = 1;
    tick();
    core_done = 0;
    check("idle_done_ign", run_count, 255);
    check("idle_no_done", led_done, 0);
    check("idle_no_run", led_run, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
